// File: rtl/pattern_inject.sv
// pattern_inject: queues CLCT injection requests and plays each one out as a
// synthetic 1/2-strip hit image on six registered layer buses.  Each image is
// the one the pattern finder would match at the requested key, with the
// requested pattern ID and all enabled layers hit.
module pattern_inject #(
  parameter int MXHS       = 160,
  parameter int MXHSB      = 8,
  parameter int MXLY       = 6,
  parameter int MXPIDB     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP        = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [MXPIDB-1:0] req_pid,
  input  logic [MXHSB-1:0]  req_key,
  input  logic [MXLY-1:0]   req_lymask,
  input  logic [3:0]        req_persist,
  output logic [MXHS-1:0]   ly0,
  output logic [MXHS-1:0]   ly1,
  output logic [MXHS-1:0]   ly2,
  output logic [MXHS-1:0]   ly3,
  output logic [MXHS-1:0]   ly4,
  output logic [MXHS-1:0]   ly5,
  output logic              inj_active,
  output logic [MXPIDB-1:0] inj_pid,
  output logic [MXHSB-1:0]  inj_key,
  output logic              fifo_full,
  output logic [15:0]       ninjected,
  output logic              err_badpid
);

  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam logic [MXHS-1:0] ONE_HS = {{(MXHS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;

  // The pop that starts the next image already falls on the last zero cycle,
  // so the GAP state itself only covers GAP-1 cycles (none when GAP is 1).
  localparam state_t     GAP_ENTRY = (GAP >= 2) ? S_GAP : S_IDLE;
  localparam logic [7:0] GAP_LOAD  = 8'((GAP >= 2) ? GAP - 2 : 0);

  typedef struct packed {
    logic [MXPIDB-1:0] pid;
    logic [MXHSB-1:0]  key;
    logic [MXLY-1:0]   lymask;
    logic [3:0]        persist;
  } entry_t;

  entry_t          fifo_mem [FIFO_DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic [PTRW:0]   count;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  entry_t          head;

  state_t          state;
  state_t          state_next;
  logic [3:0]      hold_cnt;
  logic [3:0]      hold_next;
  logic [7:0]      gap_cnt;
  logic [7:0]      gap_next;
  logic            load_img;
  logic            clr_img;
  logic            set_err;
  logic            pid_ok;

  logic [23:0]     row;
  logic [MXHS-1:0] img   [MXLY];
  logic [MXHS-1:0] ly_q  [MXLY];

  // Per-layer signed offsets for each pattern ID, packed {ly5..ly0}.
  function automatic logic [23:0] pid_offsets(input logic [MXPIDB-1:0] pid);
    case (pid)
      4'd2:    pid_offsets = {4'hC, 4'hD, 4'hF, 4'h0, 4'h2, 4'h4};
      4'd3:    pid_offsets = {4'h4, 4'h3, 4'h1, 4'h0, 4'hE, 4'hC};
      4'd4:    pid_offsets = {4'hD, 4'hD, 4'hE, 4'h0, 4'h2, 4'h3};
      4'd5:    pid_offsets = {4'h3, 4'h3, 4'h2, 4'h0, 4'hE, 4'hD};
      4'd6:    pid_offsets = {4'hE, 4'hE, 4'hF, 4'h0, 4'h1, 4'h2};
      4'd7:    pid_offsets = {4'h2, 4'h2, 4'h1, 4'h0, 4'hF, 4'hE};
      4'd8:    pid_offsets = {4'hF, 4'hF, 4'hF, 4'h0, 4'h1, 4'h1};
      4'd9:    pid_offsets = {4'h1, 4'h1, 4'h1, 4'h0, 4'hF, 4'hF};
      default: pid_offsets = '0;
    endcase
  endfunction

  // One-hot hit for a layer; positions that fall off either end are dropped.
  function automatic logic [MXHS-1:0] layer_bit(input logic [MXHSB-1:0] key,
                                                input logic            enable,
                                                input logic [3:0]      off);
    logic [MXHSB:0] pos;
    pos = {1'b0, key} + {{(MXHSB-3){off[3]}}, off};
    if (enable && !pos[MXHSB] && (pos < (MXHSB+1)'(MXHS)))
      layer_bit = ONE_HS << pos[MXHSB-1:0];
    else
      layer_bit = '0;
  endfunction

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (PTRW+1)'(FIFO_DEPTH));
  assign req_ready  = !fifo_full;
  assign push       = req_valid && !fifo_full;
  assign head       = fifo_mem[rd_ptr];
  assign pid_ok     = (head.pid >= 4'd2) && (head.pid <= 4'd10);

  // Request storage; contents need no reset because occupancy guards reads.
  always_ff @(posedge clock) begin
    if (push)
      fifo_mem[wr_ptr] <= '{pid: req_pid, key: req_key, lymask: req_lymask, persist: req_persist};
  end

  // FIFO pointers and occupancy, flushed by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Image for the request at the head of the FIFO, ready to be registered.
  always_comb begin
    row = pid_offsets(head.pid);
    for (int n = 0; n < MXLY; n++)
      img[n] = layer_bit(head.key, head.lymask[n], row[n*4 +: 4]);
  end

  // FSM state and counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      hold_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
      gap_cnt  <= gap_next;
    end
  end

  // Next-state logic: pop in IDLE, hold for persist+1 cycles, then idle gap.
  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    gap_next   = gap_cnt;
    pop        = 1'b0;
    load_img   = 1'b0;
    clr_img    = 1'b0;
    set_err    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (pid_ok) begin
            load_img   = 1'b1;
            hold_next  = head.persist;
            state_next = S_HOLD;
          end else begin
            set_err    = 1'b1;
            gap_next   = GAP_LOAD;
            state_next = GAP_ENTRY;
          end
        end
      end
      S_HOLD: begin
        if (hold_cnt == 4'd0) begin
          clr_img    = 1'b1;
          gap_next   = GAP_LOAD;
          state_next = GAP_ENTRY;
        end else begin
          hold_next = hold_cnt - 4'd1;
        end
      end
      S_GAP: begin
        if (gap_cnt == 8'd0)
          state_next = S_IDLE;
        else
          gap_next = gap_cnt - 8'd1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Registered outputs: load on a valid pop, clear and count at end of hold.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < MXLY; n++) ly_q[n] <= '0;
      inj_active <= 1'b0;
      inj_pid    <= '0;
      inj_key    <= '0;
      ninjected  <= '0;
      err_badpid <= 1'b0;
    end else begin
      if (load_img) begin
        for (int n = 0; n < MXLY; n++) ly_q[n] <= img[n];
        inj_active <= 1'b1;
        inj_pid    <= head.pid;
        inj_key    <= head.key;
      end else if (clr_img) begin
        for (int n = 0; n < MXLY; n++) ly_q[n] <= '0;
        inj_active <= 1'b0;
        inj_pid    <= '0;
        inj_key    <= '0;
        if (ninjected != 16'hFFFF) ninjected <= ninjected + 16'd1;
      end
      if (set_err) err_badpid <= 1'b1;
    end
  end

  assign ly0 = ly_q[0];
  assign ly1 = ly_q[1];
  assign ly2 = ly_q[2];
  assign ly3 = ly_q[3];
  assign ly4 = ly_q[4];
  assign ly5 = ly_q[5];

endmodule

// File: tb/tb_pattern_inject.sv
// tb_pattern_inject: table-driven and scoreboard checks for pattern_inject.
module tb_pattern_inject;

  localparam logic [8:0] NONE = 9'h1FF;

  typedef logic [5:0][159:0] image_t;

  typedef struct packed {
    image_t     ly;
    logic [3:0] pid;
    logic [7:0] key;
    logic [3:0] persist;
  } exp_t;

  typedef struct packed {
    image_t     ly;
    logic [3:0] pid;
    logic [7:0] key;
    int         dur;
    int         zeros_before;
    bit         had_prev;
    bit         stable;
  } obs_t;

  typedef struct {
    logic [3:0]      pid;
    logic [7:0]      key;
    logic [5:0]      mask;
    logic [3:0]      persist;
    logic [5:0][8:0] pos;
  } vec_t;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_pid;
  logic [7:0]   req_key;
  logic [5:0]   req_lymask;
  logic [3:0]   req_persist;
  logic [159:0] ly0, ly1, ly2, ly3, ly4, ly5;
  logic         inj_active;
  logic [3:0]   inj_pid;
  logic [7:0]   inj_key;
  logic         fifo_full;
  logic [15:0]  ninjected;
  logic         err_badpid;

  int     checks = 0;
  int     errors = 0;
  int     exp_ninj = 0;
  int     off_tbl [11][6];
  vec_t   vecs [8];
  exp_t   sb_q [$];
  obs_t   obs_q [$];

  obs_t   cur;
  bit     cur_active;
  int     zeros;
  bit     seen;
  bit     bus_dirty;

  pattern_inject dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_pid(req_pid), .req_key(req_key),
    .req_lymask(req_lymask), .req_persist(req_persist),
    .ly0(ly0), .ly1(ly1), .ly2(ly2), .ly3(ly3), .ly4(ly4), .ly5(ly5),
    .inj_active(inj_active), .inj_pid(inj_pid), .inj_key(inj_key),
    .fifo_full(fifo_full), .ninjected(ninjected), .err_badpid(err_badpid)
  );

  // 100 MHz clock.
  always #5 clock = ~clock;

  // Bus monitor: records each complete image with its length and lead-in gap.
  initial begin
    cur_active = 0; zeros = 0; seen = 0; bus_dirty = 0; cur = '0;
    forever begin
      @(negedge clock or negedge reset_n);
      if (!reset_n) begin
        cur_active = 0; zeros = 0; seen = 0;
      end else if (inj_active) begin
        if (!cur_active) begin
          cur.ly = {ly5, ly4, ly3, ly2, ly1, ly0};
          cur.pid = inj_pid; cur.key = inj_key; cur.dur = 1;
          cur.zeros_before = zeros; cur.had_prev = seen; cur.stable = 1;
          cur_active = 1;
        end else begin
          cur.dur++;
          if (cur.ly != {ly5, ly4, ly3, ly2, ly1, ly0}) cur.stable = 0;
        end
      end else begin
        if ({ly5, ly4, ly3, ly2, ly1, ly0} != '0) bus_dirty = 1;
        if (cur_active) begin
          obs_q.push_back(cur);
          cur_active = 0; seen = 1; zeros = 1;
        end else begin
          zeros++;
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0][8:0] mk_pos(input int p0, input int p1, input int p2,
                                              input int p3, input int p4, input int p5);
    int p [6];
    logic [5:0][8:0] r;
    p = '{p0, p1, p2, p3, p4, p5};
    for (int n = 0; n < 6; n++) r[n] = (p[n] < 0) ? NONE : 9'(p[n]);
    return r;
  endfunction

  task automatic set_vec(input int i, input logic [3:0] pid, input logic [7:0] key,
                         input logic [5:0] mask, input logic [3:0] persist,
                         input logic [5:0][8:0] pos);
    vecs[i].pid = pid; vecs[i].key = key; vecs[i].mask = mask;
    vecs[i].persist = persist; vecs[i].pos = pos;
  endtask

  function automatic image_t table_image(input logic [5:0][8:0] pos);
    image_t img = '0;
    for (int n = 0; n < 6; n++) if (pos[n] != NONE) img[n][pos[n]] = 1'b1;
    return img;
  endfunction

  function automatic image_t model_image(input int pid, input int key, input logic [5:0] mask);
    image_t img = '0;
    for (int n = 0; n < 6; n++) begin
      int pos = key + off_tbl[pid][n];
      if (mask[n] && pos >= 0 && pos < 160) img[n][pos] = 1'b1;
    end
    return img;
  endfunction

  // Drive one request for one edge; queue its expected image if accepted.
  task automatic apply_stimulus(input logic [3:0] pid, input logic [7:0] key,
                                input logic [5:0] mask, input logic [3:0] persist,
                                input bit expect_img, input image_t exp_ly,
                                output bit accepted);
    exp_t e;
    @(negedge clock);
    accepted = req_ready;
    req_valid = 1'b1; req_pid = pid; req_key = key;
    req_lymask = mask; req_persist = persist;
    @(posedge clock);
    if (accepted && expect_img) begin
      e.ly = exp_ly; e.pid = pid; e.key = key; e.persist = persist;
      sb_q.push_back(e);
    end
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_active(input string tag, input int budget);
    bit got = 0;
    for (int c = 0; c < budget && !got; c++) begin
      @(negedge clock);
      if (inj_active) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL %s: inj_active not seen within %0d cycles, required high", tag, budget);
    end
  endtask

  // Pop the next observed image and compare it against the scoreboard head.
  task automatic wait_image(input string tag, input int budget, input bit check_gap);
    bit got = 0;
    obs_t o;
    exp_t e;
    for (int c = 0; c < budget && !got; c++) begin
      @(posedge clock);
      #2;
      if (obs_q.size() > 0) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL %s: no image within %0d cycles, required one", tag, budget);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end else if (sb_q.size() == 0) begin
      errors++;
      void'(obs_q.pop_front());
      $display("[TB] FAIL %s: image seen, required none", tag);
    end else begin
      o = obs_q.pop_front();
      e = sb_q.pop_front();
      for (int n = 0; n < 6; n++)
        check_output($sformatf("%s ly%0d", tag, n), o.ly[n], e.ly[n]);
      check_output({tag, " inj_pid"}, 160'(o.pid), 160'(e.pid));
      check_output({tag, " inj_key"}, 160'(o.key), 160'(e.key));
      check_output({tag, " active cycles"}, 160'(o.dur), 160'(int'(e.persist) + 1));
      check_output({tag, " image stable"}, 160'(o.stable), 160'(1));
      if (exp_ninj < 16'hFFFF) exp_ninj++;
      check_output({tag, " ninjected"}, 160'(ninjected), 160'(exp_ninj));
      if (check_gap && o.had_prev)
        check_output({tag, " zero gap"}, 160'(o.zeros_before), 160'(2));
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, " ly all zero"}, 160'({ly5, ly4, ly3, ly2, ly1, ly0} != '0), 160'(0));
    check_output({tag, " inj_active"}, 160'(inj_active), 160'(0));
    check_output({tag, " inj_pid"}, 160'(inj_pid), 160'(0));
    check_output({tag, " inj_key"}, 160'(inj_key), 160'(0));
    check_output({tag, " req_ready"}, 160'(req_ready), 160'(1));
    check_output({tag, " fifo_full"}, 160'(fifo_full), 160'(0));
    check_output({tag, " ninjected"}, 160'(ninjected), 160'(0));
    check_output({tag, " err_badpid"}, 160'(err_badpid), 160'(0));
  endtask

  initial begin
    bit acc;

    off_tbl[0]  = '{0, 0, 0, 0, 0, 0};
    off_tbl[1]  = '{0, 0, 0, 0, 0, 0};
    off_tbl[2]  = '{ 4,  2, 0, -1, -3, -4};
    off_tbl[3]  = '{-4, -2, 0,  1,  3,  4};
    off_tbl[4]  = '{ 3,  2, 0, -2, -3, -3};
    off_tbl[5]  = '{-3, -2, 0,  2,  3,  3};
    off_tbl[6]  = '{ 2,  1, 0, -1, -2, -2};
    off_tbl[7]  = '{-2, -1, 0,  1,  2,  2};
    off_tbl[8]  = '{ 1,  1, 0, -1, -1, -1};
    off_tbl[9]  = '{-1, -1, 0,  1,  1,  1};
    off_tbl[10] = '{0, 0, 0, 0, 0, 0};

    set_vec(0, 4'd2,  8'd80,  6'h3F, 4'd0, mk_pos(84, 82, 80, 79, 77, 76));
    set_vec(1, 4'd3,  8'd1,   6'h3F, 4'd0, mk_pos(-1, -1, 1, 2, 4, 5));
    set_vec(2, 4'd2,  8'd158, 6'h3F, 4'd0, mk_pos(-1, -1, 158, 157, 155, 154));
    set_vec(3, 4'd9,  8'd50,  6'h04, 4'd1, mk_pos(-1, -1, 50, -1, -1, -1));
    set_vec(4, 4'd4,  8'd10,  6'h3F, 4'd2, mk_pos(13, 12, 10, 8, 7, 7));
    set_vec(5, 4'd7,  8'd159, 6'h3F, 4'd0, mk_pos(157, 158, 159, -1, -1, -1));
    set_vec(6, 4'd10, 8'd0,   6'h2A, 4'd0, mk_pos(-1, 0, -1, 0, -1, 0));
    set_vec(7, 4'd5,  8'd0,   6'h3F, 4'd0, mk_pos(-1, -1, 0, 2, 3, 3));

    reset_n = 1'b0; req_valid = 1'b0; req_pid = '0; req_key = '0;
    req_lymask = '0; req_persist = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_state("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    $display("[TB] table vectors");
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i].pid, vecs[i].key, vecs[i].mask, vecs[i].persist,
                     1'b1, table_image(vecs[i].pos), acc);
      check_output($sformatf("vec%0d accepted", i), 160'(acc), 160'(1));
      check_output($sformatf("vec%0d no image at push edge", i), 160'(inj_active), 160'(0));
      @(posedge clock);
      #1;
      check_output($sformatf("vec%0d image one edge later", i), 160'(inj_active), 160'(1));
      wait_image($sformatf("vec%0d", i), 40, 1'b0);
      repeat (3) @(negedge clock);
    end

    $display("[TB] back-to-back burst behind a long hold");
    apply_stimulus(4'd8, 8'd100, 6'h3F, 4'd15, 1'b1, model_image(8, 100, 6'h3F), acc);
    wait_active("blocker active", 20);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(4'(2 + i), 8'(40 + i), 6'h3F, 4'd3, 1'b1,
                     model_image(2 + i, 40 + i, 6'h3F), acc);
      check_output($sformatf("burst%0d accepted", i), 160'(acc), 160'(i < 4));
      if (i == 3) begin
        check_output("full after 4 pushes", 160'(fifo_full), 160'(1));
        check_output("ready low after 4 pushes", 160'(req_ready), 160'(0));
      end
    end
    wait_image("blocker", 60, 1'b0);
    for (int i = 0; i < 4; i++) wait_image($sformatf("burst%0d", i), 60, 1'b1);
    repeat (20) @(negedge clock);
    check_output("no fifth burst image", 160'(obs_q.size()), 160'(0));
    check_output("ready after drain", 160'(req_ready), 160'(1));

    $display("[TB] bad pattern ID");
    check_output("err_badpid before bad pid", 160'(err_badpid), 160'(0));
    apply_stimulus(4'd1, 8'd5, 6'h3F, 4'd0, 1'b0, '0, acc);
    apply_stimulus(4'd10, 8'd20, 6'h3F, 4'd0, 1'b1, model_image(10, 20, 6'h3F), acc);
    wait_image("pid10 after bad pid", 40, 1'b0);
    check_output("err_badpid set", 160'(err_badpid), 160'(1));
    apply_stimulus(4'd15, 8'd30, 6'h3F, 4'd0, 1'b0, '0, acc);
    repeat (10) @(negedge clock);
    check_output("err_badpid sticky", 160'(err_badpid), 160'(1));
    check_output("no image for bad pids", 160'(obs_q.size()), 160'(0));

    $display("[TB] reset during hold");
    apply_stimulus(4'd6, 8'd60, 6'h3F, 4'd15, 1'b1, model_image(6, 60, 6'h3F), acc);
    wait_active("pre-reset image active", 20);
    for (int i = 0; i < 3; i++)
      apply_stimulus(4'd7, 8'(61 + i), 6'h3F, 4'd2, 1'b1, model_image(7, 61 + i, 6'h3F), acc);
    check_output("still holding before reset", 160'(inj_active), 160'(1));
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check_reset_state("async reset");
    sb_q.delete();
    exp_ninj = 0;
    @(negedge clock);
    obs_q.delete();
    reset_n = 1'b1;
    repeat (30) @(negedge clock);
    check_output("no image after reset", 160'(obs_q.size()), 160'(0));
    check_reset_state("after release");

    check_output("bus zero while inactive", 160'(bus_dirty), 160'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_inject.md
Name: pattern_inject

Overview:
- Generates synthetic CLCT 1/2-strip hit images for a requested pattern ID (2-10) and key 1/2-strip. It is the inverse of the pattern finder.
- Each injected image is built so that the pattern finder, at that key, reports the same pattern ID with 6 hits when all layers are enabled.
- Sits upstream of the 1/2-strip layer buses. Used for self-test and firmware debug injection.
- Requests are queued in a small FIFO and played out one at a time, with a programmable hold time and a fixed inter-injection gap.

Parameters:
- MXHS, 160, 1/2-strips per layer.
- MXHSB, 8, key 1/2-strip address bits.
- MXLY, 6, number of CSC layers.
- MXPIDB, 4, pattern ID bits.
- FIFO_DEPTH, 4, request queue depth (power of 2).
- GAP, 2, all-zero cycles forced between consecutive injections (≥1).

Ports:
- clock  in  1  main clock, all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  injection request strobe.
- req_ready  out  1  FIFO can accept a request; equals !fifo_full.
- req_pid  in  MXPIDB  requested pattern ID.
- req_key  in  MXHSB  key 1/2-strip, 0..MXHS-1.
- req_lymask  in  MXLY  per-layer enable; bit n = layer n.
- req_persist  in  4  hold length; injected image is held for req_persist+1 cycles.
- ly0..ly5  out  MXHS each  registered hit images, one per layer.
- inj_active  out  1  high while ly0..ly5 carry an image.
- inj_pid  out  MXPIDB  pattern ID of the current image.
- inj_key  out  MXHSB  key of the current image.
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
- ninjected  out  16  count of completed valid injections, saturating.
- err_badpid  out  1  sticky; set on any popped request with an illegal ID.

Behaviour:
- Reset (async, reset_n=0):
  - ly0..ly5, inj_active, inj_pid, inj_key, ninjected and err_badpid all go to 0.
  - FIFO is flushed; fifo_full=0, req_ready=1.
  - FSM goes to IDLE.
  - Reset mid-injection aborts the injection immediately. The aborted injection is not counted.
- Handshake:
  - A push occurs at a rising edge where req_valid & req_ready.
  - req_valid while full is ignored; no state change.
  - Push and pop on the same edge are legal. Occupancy is then unchanged, so a full FIFO stays full.
  - All req_* fields are stored in the FIFO together.
- FSM states IDLE, HOLD, GAP:
  - IDLE: if the FIFO is non-empty, pop at this edge.
    - Valid pid: register the image, load hold counter = persist, go to HOLD.
    - Invalid pid (0, 1, 11-15): set err_badpid, drive no outputs, go to GAP.
  - HOLD: outputs are held. The counter decrements each cycle; at 0 the next edge clears the outputs, increments ninjected (saturating at 0xFFFF) and goes to GAP.
  - GAP: outputs are 0 for GAP cycles, then go to IDLE.
- Latency:
  - A request pushed at edge T into an empty FIFO, with FSM in IDLE, is popped at T+1.
  - Its image is visible from T+1 through T+1+persist. inj_active is high for exactly persist+1 cycles.
  - The next pop can occur no earlier than GAP+1 edges after the last HOLD cycle.
- Image rule:
  - Layer n carries a single bit at position key+off[pid][n], only if req_lymask[n]=1.
  - If the position is <0 or ≥MXHS, that layer's bit is dropped (no wrap). Other layers are unaffected.
  - Layer 2 (the key layer) always has offset 0.
- Offsets, listed as ly0,ly1,ly2,ly3,ly4,ly5:
  - pid 2: +4,+2,0,-1,-3,-4
  - pid 3: -4,-2,0,+1,+3,+4
  - pid 4: +3,+2,0,-2,-3,-3
  - pid 5: -3,-2,0,+2,+3,+3
  - pid 6: +2,+1,0,-1,-2,-2
  - pid 7: -2,-1,0,+1,+2,+2
  - pid 8: +1,+1,0,-1,-1,-1
  - pid 9: -1,-1,0,+1,+1,+1
  - pid 10: 0,0,0,0,0,0
- Offset arithmetic: offsets are signed 4-bit. The position is computed as a sign-extended (MXHSB+1)-bit sum, and its range is checked before decode.
- Outputs: all outputs are registered. There is no combinational path from req_* to ly*.

Test Plan:
- Single request (pid=2, key=80, mask=3F, persist=0) into an idle block, then an idle bus. Required response:
  - Bits set are ly0[84], ly1[82], ly2[80], ly3[79], ly4[77], ly5[76].
  - Image and inj_active are high for 1 cycle; ninjected=1.
- Edge clipping: pid=3, key=1, mask=3F. Required response:
  - ly0 and ly1 are all-zero.
  - Bits set are ly2[1], ly3[2], ly4[4], ly5[5].
  - Same test with pid=2, key=158: ly0 and ly1 are zero, other layers are set.
- Back-to-back push of 5 requests, persist=3. Required response:
  - req_ready drops after the 4th push (5th push ignored while full).
  - Each image holds 4 cycles, separated by 2 zero cycles.
  - ninjected=4 at the end.
- Bad ID: push pid=1, then pid=10 key=20. Required response:
  - err_badpid=1 and stays set.
  - No image for the first request; the second gives all layers' bit 20; ninjected=1.
- Layer mask: pid=9, key=50, mask=6'b000100. Required response:
  - Only ly2[50] is set; inj_pid=9; inj_key=50.
- Reset mid-op: reset_n low during HOLD with 3 requests queued. Required response:
  - Outputs clear asynchronously and the FIFO is empty.
  - After release, req_ready=1, ninjected=0, err_badpid=0 and there is no image.
